// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//   Multi-cycle instruction sequencer. It issues a one-cycle start pulse per
//   pipeline stage and waits for that stage's finish pulse before it moves on.
//   Features:
//   - per-instruction stage skipping (skip mask sampled at each advance)
//   - redirect flush back to stage 0
//   - stuck-stage watchdog with a sticky HALT
//   - retired-instruction counter
//   - commit delay line used to align difftest valid
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   start_en     run enable, consulted only when a new instruction would start
//   stage_done   per-stage finish pulses; only the active stage's bit is used
//   stage_skip   per-stage skip mask; bit 0 (fetch) is never skipped
//   redirect     abandon the current instruction and restart at stage 0
//   stage_valid  one-cycle start pulse in the entry cycle of a stage
//   cur_stage    one-hot active stage; 0 in IDLE and HALT
//   commit       one-cycle retire pulse
//   commit_dly   commit delayed by COMMIT_DELAY cycles
//   instr_cnt    retired-instruction count (wraps)
//   timeout      sticky watchdog trip flag
//   idle         high while in IDLE
// -----------------------------------------------------------------------------
module stage_sequencer #(
    parameter int NUM_STAGES   = 5,
    parameter int COMMIT_DELAY = 2,
    parameter int TIMEOUT_W    = 16,
    parameter int CNT_W        = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_en,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic [NUM_STAGES-1:0] stage_skip,
    input  logic                  redirect,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [NUM_STAGES-1:0] cur_stage,
    output logic                  commit,
    output logic                  commit_dly,
    output logic [CNT_W-1:0]      instr_cnt,
    output logic                  timeout,
    output logic                  idle
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [NUM_STAGES-1:0] FIRST_STAGE = NUM_STAGES'(1);
    localparam logic [TIMEOUT_W-1:0]  WD_MAX      = '1;

    logic [1:0]            state_q, state_d;
    logic [NUM_STAGES-1:0] cur_stage_q, cur_stage_d;
    logic [NUM_STAGES-1:0] stage_valid_q, stage_valid_d;
    logic                  commit_q, commit_d;
    logic [CNT_W-1:0]      instr_cnt_q, instr_cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  idle_q, idle_d;
    logic [TIMEOUT_W-1:0]  wd_cnt_q, wd_cnt_d;

    // Stages strictly after the active one. Bit 0 is never "later", which is
    // what makes the fetch skip bit irrelevant.
    logic [NUM_STAGES-1:0] later_mask;
    logic [NUM_STAGES-1:0] next_cand;
    logic [NUM_STAGES-1:0] next_onehot;
    logic                  done_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_later
            if (gi == 0) begin : g_first
                assign later_mask[gi] = 1'b0;
            end else begin : g_rest
                assign later_mask[gi] = |cur_stage_q[gi-1:0];
            end
        end
    endgenerate

    assign next_cand   = later_mask & ~stage_skip;
    // Isolate the lowest set bit: the nearest non-skipped later stage.
    assign next_onehot = next_cand & (~next_cand + FIRST_STAGE);
    assign done_hit    = |(stage_done & cur_stage_q);

    always_comb begin
        state_d       = state_q;
        cur_stage_d   = cur_stage_q;
        stage_valid_d = '0;
        commit_d      = 1'b0;
        instr_cnt_d   = instr_cnt_q;
        timeout_d     = timeout_q;
        wd_cnt_d      = wd_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_en) begin
                    state_d       = S_RUN;
                    cur_stage_d   = FIRST_STAGE;
                    stage_valid_d = FIRST_STAGE;
                    wd_cnt_d      = '0;
                end
            end
            S_RUN: begin
                // Redirect and retire share the same restart decision.
                if (redirect || (done_hit && next_cand == '0)) begin
                    if (!redirect) begin
                        commit_d    = 1'b1;
                        instr_cnt_d = instr_cnt_q + CNT_W'(1);
                    end
                    wd_cnt_d = '0;
                    if (start_en) begin
                        cur_stage_d   = FIRST_STAGE;
                        stage_valid_d = FIRST_STAGE;
                    end else begin
                        state_d     = S_IDLE;
                        cur_stage_d = '0;
                    end
                end else if (done_hit) begin
                    cur_stage_d   = next_onehot;
                    stage_valid_d = next_onehot;
                    wd_cnt_d      = '0;
                end else if (wd_cnt_q == WD_MAX) begin
                    state_d     = S_HALT;
                    cur_stage_d = '0;
                    timeout_d   = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + TIMEOUT_W'(1);
                end
            end
            S_HALT: begin
                cur_stage_d = '0;
            end
            default: begin
                state_d     = S_IDLE;
                cur_stage_d = '0;
            end
        endcase

        idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cur_stage_q   <= '0;
            stage_valid_q <= '0;
            commit_q      <= 1'b0;
            instr_cnt_q   <= '0;
            timeout_q     <= 1'b0;
            idle_q        <= 1'b1;
            wd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            cur_stage_q   <= cur_stage_d;
            stage_valid_q <= stage_valid_d;
            commit_q      <= commit_d;
            instr_cnt_q   <= instr_cnt_d;
            timeout_q     <= timeout_d;
            idle_q        <= idle_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    // Commit delay line; shifts every cycle regardless of state.
    generate
        if (COMMIT_DELAY == 0) begin : g_nodly
            assign commit_dly = commit_q;
        end else begin : g_dly
            logic [COMMIT_DELAY-1:0] dly_q, dly_d;
            for (gi = 0; gi < COMMIT_DELAY; gi++) begin : g_tap
                if (gi == 0) begin : g_head
                    assign dly_d[gi] = commit_q;
                end else begin : g_body
                    assign dly_d[gi] = dly_q[gi-1];
                end
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= dly_d;
                end
            end
            assign commit_dly = dly_q[COMMIT_DELAY-1];
        end
    endgenerate

    assign stage_valid = stage_valid_q;
    assign cur_stage   = cur_stage_q;
    assign commit      = commit_q;
    assign instr_cnt   = instr_cnt_q;
    assign timeout     = timeout_q;
    assign idle        = idle_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//   Drives stage_sequencer with directed phases of random stimulus. A
//   behavioural model tracks the instruction (mode, stage index, wait cycles,
//   retire count, commit history) from the sequencing rules. Every cycle the
//   bench compares all DUT outputs against that model.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

    localparam int NS = 5;
    localparam int CD = 2;
    localparam int TW = 4;
    localparam int CW = 8;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_en;
    logic [NS-1:0] stage_done;
    logic [NS-1:0] stage_skip;
    logic          redirect;
    logic [NS-1:0] stage_valid;
    logic [NS-1:0] cur_stage;
    logic          commit;
    logic          commit_dly;
    logic [CW-1:0] instr_cnt;
    logic          timeout;
    logic          idle;

    stage_sequencer #(
        .NUM_STAGES  (NS),
        .COMMIT_DELAY(CD),
        .TIMEOUT_W   (TW),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_en   (start_en),
        .stage_done (stage_done),
        .stage_skip (stage_skip),
        .redirect   (redirect),
        .stage_valid(stage_valid),
        .cur_stage  (cur_stage),
        .commit     (commit),
        .commit_dly (commit_dly),
        .instr_cnt  (instr_cnt),
        .timeout    (timeout),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_mode;
    int m_k;
    int m_wait;
    int m_cnt;
    int m_valid;      // stage started this cycle, -1 if none
    bit m_commit;
    bit m_timeout;
    bit m_line [CD];  // pending commit history, oldest at the end

    int checks;
    int errors;
    int cyc;
    int n_commits;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic restart();
        if (start_en) begin
            m_mode  = M_RUN;
            m_k     = 0;
            m_valid = 0;
            m_wait  = 0;
        end else begin
            m_mode = M_IDLE;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit cm_prev;
        int j;
        cm_prev  = m_commit;
        m_valid  = -1;
        m_commit = 1'b0;
        if (rst) begin
            m_mode    = M_IDLE;
            m_k       = 0;
            m_wait    = 0;
            m_cnt     = 0;
            m_timeout = 1'b0;
            for (int i = 0; i < CD; i++) m_line[i] = 1'b0;
        end else begin
            for (int i = CD - 1; i > 0; i--) m_line[i] = m_line[i-1];
            m_line[0] = cm_prev;
            case (m_mode)
                M_IDLE: restart();
                M_RUN: begin
                    if (redirect) begin
                        restart();
                    end else if (stage_done[m_k]) begin
                        j = -1;
                        for (int s = NS - 1; s > m_k; s--)
                            if (!stage_skip[s]) j = s;
                        if (j >= 0) begin
                            m_k     = j;
                            m_valid = j;
                            m_wait  = 0;
                        end else begin
                            m_commit = 1'b1;
                            m_cnt    = (m_cnt + 1) % (1 << CW);
                            restart();
                        end
                    end else if (m_wait == (1 << TW) - 1) begin
                        m_mode    = M_HALT;
                        m_timeout = 1'b1;
                    end else begin
                        m_wait++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step();
        logic [NS-1:0] ev;
        logic [NS-1:0] ec;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        ev = '0;
        ec = '0;
        if (m_valid >= 0) ev[m_valid] = 1'b1;
        if (m_mode == M_RUN) ec[m_k] = 1'b1;
        chk("stage_valid", 64'(stage_valid), 64'(ev));
        chk("cur_stage",   64'(cur_stage),   64'(ec));
        chk("commit",      64'(commit),      64'(m_commit));
        chk("commit_dly",  64'(commit_dly),  64'(m_line[CD-1]));
        chk("instr_cnt",   64'(instr_cnt),   64'(m_cnt));
        chk("timeout",     64'(timeout),     64'(m_timeout));
        chk("idle",        64'(idle),        64'(m_mode == M_IDLE));
        if (m_commit) begin
            n_commits++;
            $display("commit %0d: cycle %0d instr_cnt %0d", n_commits, cyc, m_cnt);
        end
    endtask

    // Randomised input drive. Probabilities in percent, p_rst in per-mille.
    // need_wait delays the active stage's done until one cycle after entry.
    task automatic drive(input int p_done, input int p_redir, input int p_start,
                         input int p_skip, input int p_rst, input bit need_wait);
        rst      = ($urandom_range(999) < p_rst);
        start_en = ($urandom_range(99) < p_start);
        redirect = ($urandom_range(99) < p_redir);
        for (int i = 0; i < NS; i++) stage_skip[i] = ($urandom_range(99) < p_skip);
        stage_done = NS'($urandom);
        stage_done[m_k] = ($urandom_range(99) < p_done) && (!need_wait || m_wait >= 1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        n_commits = 0;
        m_mode    = M_IDLE;
        m_k       = 0;
        m_wait    = 0;
        m_cnt     = 0;
        m_valid   = -1;
        m_commit  = 1'b0;
        m_timeout = 1'b0;
        for (int i = 0; i < CD; i++) m_line[i] = 1'b0;

        rst        = 1'b1;
        start_en   = 1'b0;
        redirect   = 1'b0;
        stage_done = '0;
        stage_skip = '0;

        // Reset state
        step();
        step();
        chk("reset_idle", 64'(idle), 64'd1);

        // Base flow: done one cycle after each start, no skips
        for (int i = 0; i < 40; i++) begin
            drive(100, 0, 100, 0, 0, 1'b1);
            step();
        end

        // Zero-latency stages
        for (int i = 0; i < 40; i++) begin
            drive(100, 0, 100, 0, 0, 1'b0);
            step();
        end

        // Mixed random traffic: skips, redirects, start_en gaps, rare resets
        for (int i = 0; i < 1500; i++) begin
            drive(55, 6, 80, 35, 5, 1'b0);
            step();
        end

        // Watchdog: stall the active stage until HALT, then hammer inputs
        for (int r = 0; r < 4; r++) begin
            rst = 1'b1;
            step();
            for (int i = 0; i < 8 * r; i++) begin
                drive(100, 0, 100, 20, 0, 1'b0);
                step();
            end
            for (int i = 0; i < 25; i++) begin
                drive(0, 0, 100, 0, 0, 1'b0);
                stage_done = '0;
                step();
            end
            chk("halt_reached", 64'(timeout), 64'd1);
            for (int i = 0; i < 12; i++) begin
                drive(60, 40, 50, 30, 0, 1'b0);
                step();
            end
        end

        // Reset immediately after a commit: the delayed commit must be dropped
        rst = 1'b1;
        step();
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                drive(100, 0, 100, 0, 0, 1'b1);
                step();
                got = m_commit;
            end
            chk("commit_before_reset", 64'(got), 64'd1);
        end
        rst = 1'b1;
        step();
        rst      = 1'b0;
        start_en = 1'b0;
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Long zero-latency run with random skips to wrap instr_cnt
        for (int i = 0; i < 1500; i++) begin
            drive(100, 2, 95, 40, 0, 1'b0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
